// File: rtl/mem_alu_arb.sv
// -----------------------------------------------------------------------------
// mem_alu_arb
//
// Two-requester round-robin arbiter and transaction sequencer for the shared
// mem_alu register/ALU block. Read/write requests arrive on two valid/ready
// ports. One transaction at a time goes onto the mem_alu bus. Read results
// return, after the fixed read latency, to the requester that issued the read.
//
// Optional build macro: MEM_ALU_ARB_STATS_EN
//   defined     -> saturating 16-bit per-requester grant counters on grant_cntN
//   not defined -> grant_cntN tied to 0, no counter flops
//
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   reqN_valid/ready            request handshake (ready combinational, IDLE only)
//   reqN_rd_wr/addr/wr_data     request fields (1 = read, 0 = write)
//   rspN_valid                  one-cycle read-response pulse
//   rspN_rd_data/rspN_res       captured read data / ALU result (held)
//   mem_rd_wr/addr/enable/
//   mem_wr_data                 registered drive to mem_alu
//   mem_rd_data/mem_res_out     read return from mem_alu
//   grant_cntN                  grant statistics (see macro above)
//
// Parameters
//   ADDR_WIDTH, DATA_WIDTH, RES_WIDTH  bus widths
//   RD_LAT  cycles from the enable-high issue cycle to valid read data (1..7)
// -----------------------------------------------------------------------------
module mem_alu_arb #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 16,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_rd_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wr_data,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_rd_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wr_data,

  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rd_data,
  output logic [RES_WIDTH-1:0]  rsp0_res,

  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rd_data,
  output logic [RES_WIDTH-1:0]  rsp1_res,

  output logic                  mem_rd_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_enable,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic [RES_WIDTH-1:0]  mem_res_out,

  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q;
  logic            last_q;   // id of the most recent grant; reset to 1 so req0 is favoured
  logic            id_q;     // id of the in-flight requester
  logic [2:0]      wait_q;   // remaining WAIT cycles

  logic                  any_valid;
  logic                  win_id;
  logic                  grant;
  logic                  sel_rd_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wr_data;

  // Arbitration: a lone requester wins; with both valid, the one not granted
  // last time wins.
  // NOTE: every always_comb output gets a default-free full assignment on all
  // paths, so no latch can be inferred.
  always_comb begin
    any_valid   = req0_valid | req1_valid;
    win_id      = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    grant       = (state_q == IDLE) & any_valid;
    sel_rd_wr   = win_id ? req1_rd_wr   : req0_rd_wr;
    sel_addr    = win_id ? req1_addr    : req0_addr;
    sel_wr_data = win_id ? req1_wr_data : req0_wr_data;
  end

  // Ready ports are forced low while reset is asserted; the gating stays on the
  // port path only so reset never feeds flop data inputs.
  assign req0_ready = reset & grant & ~win_id;
  assign req1_ready = reset & grant &  win_id;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the mem_* and rsp* data registers are reset too, because every
      // output must read 0 while reset is held.
      state_q      <= IDLE;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      wait_q       <= '0;
      mem_rd_wr    <= 1'b0;
      mem_addr     <= '0;
      mem_enable   <= 1'b0;
      mem_wr_data  <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_rd_data <= '0;
      rsp0_res     <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_rd_data <= '0;
      rsp1_res     <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      mem_enable <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            // The mem_* registers double as the request latch; they hold their
            // value until the next accept.
            mem_rd_wr   <= sel_rd_wr;
            mem_addr    <= sel_addr;
            mem_wr_data <= sel_wr_data;
            mem_enable  <= 1'b1;
            id_q        <= win_id;
            last_q      <= win_id;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_rd_wr) begin
            state_q <= IDLE;
          end else if (RD_LAT == 1) begin
            state_q <= RESP;
          end else begin
            wait_q  <= 3'(RD_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          wait_q <= wait_q - 3'd1;
          if (wait_q == 3'd1) state_q <= RESP;
        end
        RESP: begin
          if (id_q) begin
            rsp1_rd_data <= mem_rd_data;
            rsp1_res     <= mem_res_out;
            rsp1_valid   <= 1'b1;
          end else begin
            rsp0_rd_data <= mem_rd_data;
            rsp0_res     <= mem_res_out;
            rsp0_valid   <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0_q;
  logic [15:0] grant_cnt1_q;

  // Saturating grant counters: stick at 16'hFFFF instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else if (grant) begin
      if (!win_id && grant_cnt0_q != 16'hFFFF) grant_cnt0_q <= grant_cnt0_q + 16'd1;
      if ( win_id && grant_cnt1_q != 16'hFFFF) grant_cnt1_q <= grant_cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule
